serial_rx: RTL and testbench

Asynchronous serial receiver; the stage directly downstream of `serial_tx`. Watches a single idle-high line, detects a start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Each good byte is presented on a parallel bus with a one-cycle valid strobe. The frame format matches `serial_tx` exactly, so the two blocks loop back on one board.

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_bit_timer.sv | 34 +++
 rtl/serial_rx.sv | 151 +++++++++++++++
 tb/tb_serial_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by serial_rx and serial_tx.
package serial_pkg;

  localparam int SERIAL_DATA_BITS    = 8;
  localparam int SERIAL_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period down-counter: tick when the loaded half/full period expires, then auto-reloads a full period.
// Latency: tick appears count cycles after clear; no backpressure.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = SERIAL_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_LD = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LD = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] cnt_q;

  assign tick = run && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= FULL_LD;
    end else if (clear) begin
      cnt_q <= half ? HALF_LD : FULL_LD;
    end else if (run) begin
      cnt_q <= (cnt_q == '0) ? FULL_LD : cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver, mid-bit sampling; result strobe at E+h+9*CLKS_PER_BIT+1, no backpressure.
// Define SERIAL_RX_SYNC_EN to add a 2-flop input synchronizer (+2 cycles latency).
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = SERIAL_CLKS_PER_BIT
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        data_in,
  output logic [SERIAL_DATA_BITS-1:0] val_out,
  output logic                        valid_out,
  output logic                        busy_out,
  output logic                        framing_err_out
);

  localparam int IW = $clog2(SERIAL_DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(SERIAL_DATA_BITS - 1);

  logic s;
  logic s_prev;

`ifdef SERIAL_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], data_in};
    end
  end

  assign s = sync_q[1];
`else
  assign s = data_in;
`endif

  // Previous sample resets high so a line that is low out of reset is not a start edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s_prev <= 1'b1;
    end else begin
      s_prev <= s;
    end
  end

  rx_state_t state_q, state_d;
  logic                        tmr_clear;
  logic                        tmr_half;
  logic                        tick;
  logic                        shift_en;
  logic                        idx_clear;
  logic                        done_ok;
  logic                        done_err;
  logic [IW-1:0]               idx_q;
  logic [SERIAL_DATA_BITS-1:0] sr_q;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .run   (state_q != IDLE),
    .clear (tmr_clear),
    .half  (tmr_half),
    .tick  (tick)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_clear = 1'b0;
    tmr_half  = 1'b0;
    shift_en  = 1'b0;
    idx_clear = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_prev && !s) begin
          tmr_clear = 1'b1;
          tmr_half  = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          if (s) begin
            state_d = IDLE;
          end else begin
            tmr_clear = 1'b1;
            idx_clear = 1'b1;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leaving mid-stop-bit gives half a bit of margin for the next start edge.
        if (tick) begin
          done_ok  = s;
          done_err = !s;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx_q           <= '0;
      sr_q            <= '0;
      val_out         <= '0;
      valid_out       <= 1'b0;
      framing_err_out <= 1'b0;
    end else begin
      if (idx_clear) begin
        idx_q <= '0;
      end else if (shift_en) begin
        idx_q <= idx_q + 1'b1;
      end
      if (shift_en) begin
        sr_q[idx_q] <= s;
      end
      if (done_ok) begin
        val_out <= sr_q;
      end
      valid_out       <= done_ok;
      framing_err_out <= done_err;
    end
  end

  assign busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx with CLKS_PER_BIT=8; expected timing adapts to SERIAL_RX_SYNC_EN.
module tb_serial_rx;

  localparam int C = 8;
  localparam int H = C / 2;
`ifdef SERIAL_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = SYNC + H + 9 * C + 1;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       data_in;
  logic [7:0] val_out;
  logic       valid_out;
  logic       busy_out;
  logic       framing_err_out;

  serial_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .data_in         (data_in),
    .val_out         (val_out),
    .valid_out       (valid_out),
    .busy_out        (busy_out),
    .framing_err_out (framing_err_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [7:0] vq[$];
  int         vcq[$];
  int         fcnt = 0;
  int         bcnt = 0;
  int         both = 0;

  always @(negedge clk_in) begin
    if (valid_out) begin
      vq.push_back(val_out);
      vcq.push_back(cyc);
    end
    if (framing_err_out) fcnt++;
    if (valid_out && framing_err_out) both++;
    if (busy_out) bcnt++;
  end

  task automatic clr_mon();
    vq.delete();
    vcq.delete();
    fcnt = 0;
    bcnt = 0;
    both = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  int fall_cyc;

  // Caller is #1 after a rising edge; each bit is held exactly C cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    data_in  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(C);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      wait_cyc(C);
    end
    data_in = stop_bit;
    wait_cyc(C);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int f0;

  initial begin
    rst_n_in = 1'b0;
    data_in  = 1'b1;
    wait_cyc(3);
    check("rst_val", val_out, 8'h00);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_ferr", framing_err_out, 0);
    rst_n_in = 1'b1;
    wait_cyc(10);

    // Single frame 0x8E
    clr_mon();
    send_byte(8'h8E, 1'b1);
    wait_cyc(5);
    check("8e_count", vq.size(), 1);
    check("8e_value", (vq.size() > 0) ? vq[0] : 8'hxx, 8'h8E);
    check("8e_latency", (vcq.size() > 0) ? vcq[0] - fall_cyc : -1, LAT);
    check("8e_val_out", val_out, 8'h8E);
    check("8e_busy_after", busy_out, 0);
    check("8e_busy_cycles", bcnt, H + 9 * C);
    check("8e_no_ferr", fcnt, 0);

    // Back-to-back 0x00 then 0xFF, single stop bit between them
    clr_mon();
    send_byte(8'h00, 1'b1);
    f0 = fall_cyc;
    send_byte(8'hFF, 1'b1);
    wait_cyc(5);
    check("b2b_count", vq.size(), 2);
    check("b2b_first", (vq.size() > 0) ? vq[0] : 8'hxx, 8'h00);
    check("b2b_second", (vq.size() > 1) ? vq[1] : 8'hxx, 8'hFF);
    check("b2b_first_lat", (vcq.size() > 0) ? vcq[0] - f0 : -1, LAT);
    check("b2b_spacing", (vcq.size() > 1) ? vcq[1] - vcq[0] : -1, 10 * C);
    check("b2b_no_ferr", fcnt, 0);

    // False start: two low cycles
    clr_mon();
    data_in = 1'b0;
    wait_cyc(2);
    data_in = 1'b1;
    wait_cyc(30);
    check("fs_busy_cycles", bcnt, H);
    check("fs_no_valid", vq.size(), 0);
    check("fs_no_ferr", fcnt, 0);
    check("fs_busy_after", busy_out, 0);

    // Framing error: 0x55 with low stop bit, then line held low
    clr_mon();
    send_byte(8'h55, 1'b0);
    wait_cyc(2);
    check("fe_pulses", fcnt, 1);
    check("fe_no_valid", vq.size(), 0);
    check("fe_val_kept", val_out, 8'hFF);
    check("fe_never_both", both, 0);
    clr_mon();
    wait_cyc(40);
    check("break_no_busy", bcnt, 0);
    check("break_no_ferr", fcnt, 0);
    data_in = 1'b1;
    wait_cyc(10);

    // Frame as serial_tx would emit it for val_in=0x3C
    clr_mon();
    send_byte(8'h3C, 1'b1);
    wait_cyc(5);
    check("lb_count", vq.size(), 1);
    check("lb_value", val_out, 8'h3C);

    // Reset asserted during data bit 4
    clr_mon();
    fork
      send_byte(8'hC3, 1'b1);
      begin
        wait_cyc(5 * C + 3);
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_val", val_out, 8'h00);
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_ferr", framing_err_out, 0);
      end
    join
    wait_cyc(5);
    rst_n_in = 1'b1;
    wait_cyc(10);
    check("post_rst_no_valid", vq.size(), 0);
    clr_mon();
    send_byte(8'hA5, 1'b1);
    wait_cyc(5);
    check("a5_count", vq.size(), 1);
    check("a5_value", val_out, 8'hA5);
    check("a5_latency", (vcq.size() > 0) ? vcq[0] - fall_cyc : -1, LAT);
    check("a5_no_ferr", fcnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
